cmp_seq_nb: RTL

// - Sequential WIDTH-bit magnitude comparator. It consumes the same eq/lt/gt decision the 2-bit comparator stage makes, applied one 2-bit digit per clock.
// - Captures two operands on start and scans 2-bit digits MSB-first, stopping at the first unequal digit.
// - Reports eq/lt/gt with a one-cycle done pulse. Sits downstream of operand registers; feeds status/branch logic.

---
 rtl/cmp_seq_nb.sv | 105 ++++++++++
 1 files changed

// File: rtl/cmp_seq_nb.sv
// cmp_seq_nb: sequential magnitude comparator scanning 2-bit digits MSB-first (SIGNED_CMP_EN selects signed ordering)
module cmp_seq_nb #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             lt,
  output logic             gt,
  output logic [CNTW-1:0]  ndig
);
  localparam logic [CNTW-1:0] DIG = CNTW'(WIDTH / 2);
  localparam logic [CNTW-1:0] TOP = CNTW'(WIDTH / 2 - 1);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] xr_q, xr_d, yr_q, yr_d, xs, ys, cur_x, cur_y;
  logic [CNTW-1:0] idx_q, idx_d, cur_idx, ndig_q, ndig_d;
  logic done_q, done_d, eq_q, eq_d, lt_q, lt_d, gt_q, gt_d;
  logic [1:0] dx, dy;
  logic scan, act;
`ifdef SIGNED_CMP_EN
  assign xs = {~x[WIDTH-1], x[WIDTH-2:0]};
  assign ys = {~y[WIDTH-1], y[WIDTH-2:0]};
`else
  assign xs = x;
  assign ys = y;
`endif
  // The top digit is judged on the live operands in the accept cycle, so k digits finish at T+k
  assign scan    = state_q == SCAN;
  assign act     = scan | start;
  assign cur_x   = scan ? xr_q : xs;
  assign cur_y   = scan ? yr_q : ys;
  assign cur_idx = scan ? idx_q : TOP;
  assign dx      = 2'(cur_x >> {cur_idx, 1'b0});
  assign dy      = 2'(cur_y >> {cur_idx, 1'b0});
  // Next state: capture on accept, stop at first unequal digit or after the last digit
  always_comb begin
    state_d = state_q;
    xr_d    = xr_q;
    yr_d    = yr_q;
    idx_d   = idx_q;
    ndig_d  = ndig_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    gt_d    = gt_q;
    done_d  = 1'b0;
    if (act) begin
      if (!scan) begin
        xr_d   = xs;
        yr_d   = ys;
        eq_d   = 1'b0;
        lt_d   = 1'b0;
        gt_d   = 1'b0;
        ndig_d = '0;
      end
      if (dx != dy || cur_idx == '0) begin
        eq_d    = dx == dy;
        lt_d    = dx < dy;
        gt_d    = dx > dy;
        ndig_d  = DIG - cur_idx;
        done_d  = 1'b1;
        state_d = IDLE;
      end else begin
        idx_d   = cur_idx - CNTW'(1);
        state_d = SCAN;
      end
    end
  end
  // State and result registers; reset discards any partial scan
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      xr_q    <= '0;
      yr_q    <= '0;
      idx_q   <= '0;
      ndig_q  <= '0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xr_q    <= xr_d;
      yr_q    <= yr_d;
      idx_q   <= idx_d;
      ndig_q  <= ndig_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
      done_q  <= done_d;
    end
  end
  assign busy = scan;
  assign done = done_q;
  assign eq   = eq_q;
  assign lt   = lt_q;
  assign gt   = gt_q;
  assign ndig = ndig_q;
endmodule
